// File: rtl/tug_pkg.sv
// Shared constants and types for the tug-of-war playfield.
// Optional feature macro used by the top: TUG_CPU_PLAYER_EN.
package tug_pkg;

  localparam int NUM_LIGHTS_DEF = 9;

  // Centre light index for an odd-length bar.
  function automatic int center(input int num_lights);
    return num_lights / 2;
  endfunction

  localparam int CENTER_DEF = NUM_LIGHTS_DEF / 2;

  typedef logic [$clog2(NUM_LIGHTS_DEF)-1:0] pos_t;

  // CPU player pseudo-random source: Fibonacci LFSR x^10 + x^7 + 1.
  localparam int              LFSR_W     = 10;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 10'h001;
  localparam int              LFSR_TAP_A = 9;
  localparam int              LFSR_TAP_B = 6;

  typedef logic [LFSR_W-1:0] lfsr_t;

endpackage

// File: rtl/tug_playfield_key_conditioner.sv
// Raw key conditioning: 2-flop synchronizer, rising-edge detect and a
// registered one-cycle pulse. A key sampled high before edge k produces
// a pulse during the cycle after edge k+2.
module key_conditioner (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic pulse
);

  logic sync1_q, sync2_q, prev_q, pulse_q;
  logic pulse_d;

  // Rising edge of the synchronized key.
  always_comb begin
    pulse_d = sync2_q & ~prev_q;
  end

  // Synchronizer chain, edge history and registered pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/tug_playfield.sv
// Tug-of-war playfield: conditions both player keys and moves a single lit
// LED along an odd-length bar, one step per press, saturating at the ends.
// Define TUG_CPU_PLAYER_EN to replace the right player with an LFSR-driven
// CPU opponent (adds the cpu_level port; key_r is then ignored).
module tug_playfield
  import tug_pkg::*;
#(
  parameter int NUM_LIGHTS = NUM_LIGHTS_DEF,
  parameter int CPU_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  key_l,
  input  logic                  key_r,
  input  logic                  halt,
`ifdef TUG_CPU_PLAYER_EN
  input  logic [2:0]            cpu_level,
`endif
  output logic [NUM_LIGHTS-1:0] leds,
  output logic                  l_on,
  output logic                  r_on,
  output logic                  l_press,
  output logic                  r_press
);

  localparam int                    POS_W    = $clog2(NUM_LIGHTS);
  localparam logic [POS_W-1:0]      POS_RST  = POS_W'(center(NUM_LIGHTS));
  localparam logic [POS_W-1:0]      POS_MAX  = POS_W'(NUM_LIGHTS - 1);
  localparam logic [NUM_LIGHTS-1:0] LEDS_RST = NUM_LIGHTS'(1) << center(NUM_LIGHTS);

  logic                  l_press_w;
  logic                  r_press_w;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic [NUM_LIGHTS-1:0] leds_q, leds_d;

  key_conditioner u_key_l (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (key_l),
    .pulse   (l_press_w)
  );

`ifdef TUG_CPU_PLAYER_EN
  logic [CPU_DIV-1:0] div_q;
  lfsr_t              lfsr_q;
  logic               cpu_press_q;
  logic               tick;
  logic               unused_key_r;

  assign unused_key_r = key_r;
  assign tick         = &div_q;

  // CPU opponent: on each divider wrap, press if the LFSR's top bits fall
  // below the aggressiveness level, then advance the LFSR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      cpu_press_q <= 1'b0;
    end else begin
      div_q       <= div_q + CPU_DIV'(1);
      cpu_press_q <= tick && (lfsr_q[LFSR_W-1 -: 3] < cpu_level);
      if (tick) begin
        lfsr_q <= {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
      end
    end
  end

  assign r_press_w = cpu_press_q;
`else
  key_conditioner u_key_r (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (key_r),
    .pulse   (r_press_w)
  );
`endif

  // Next light position: one step per lone press, saturating, frozen by halt.
  always_comb begin
    pos_d  = pos_q;
    leds_d = leds_q;
    if (!halt) begin
      if (l_press_w && !r_press_w && (pos_q != POS_MAX)) begin
        pos_d  = pos_q + POS_W'(1);
        leds_d = leds_q << 1;
      end else if (r_press_w && !l_press_w && (pos_q != '0)) begin
        pos_d  = pos_q - POS_W'(1);
        leds_d = leds_q >> 1;
      end
    end
  end

  // Position and one-hot bar registers; the bar lags the press by one cycle
  // so downstream sees a press together with the old end-light state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_q  <= POS_RST;
      leds_q <= LEDS_RST;
    end else begin
      pos_q  <= pos_d;
      leds_q <= leds_d;
    end
  end

  assign leds    = leds_q;
  assign l_on    = leds_q[NUM_LIGHTS-1];
  assign r_on    = leds_q[0];
  assign l_press = l_press_w;
  assign r_press = r_press_w;

endmodule

// File: tb/tb_tug_playfield.sv
// Self-checking bench for tug_playfield: directed scenarios plus randomized
// key/halt traffic compared against a behavioural model of the playfield.
module tb_tug_playfield;

  localparam int N   = 9;
  localparam int DIV = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         key_l = 1'b0;
  logic         key_r = 1'b0;
  logic         halt = 1'b0;
`ifdef TUG_CPU_PLAYER_EN
  logic [2:0]   cpu_level = 3'd0;
`endif
  logic [N-1:0] leds;
  logic         l_on, r_on, l_press, r_press;

  int total = 0;
  int bad   = 0;

  // Model state
  logic hl[$];
  logic hr[$];
  int   pos;
  bit   pl_prev, pr_prev;
  int   n;
  int   lfsr;
  int   lp_cnt = 0;
  int   rp_cnt = 0;

  always #5 clk = ~clk;

  tug_playfield #(.NUM_LIGHTS(N), .CPU_DIV(DIV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_l     (key_l),
    .key_r     (key_r),
    .halt      (halt),
`ifdef TUG_CPU_PLAYER_EN
    .cpu_level (cpu_level),
`endif
    .leds      (leds),
    .l_on      (l_on),
    .r_on      (r_on),
    .l_press   (l_press),
    .r_press   (r_press)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hl = '{1'b0, 1'b0, 1'b0, 1'b0};
    hr = '{1'b0, 1'b0, 1'b0, 1'b0};
    pos = N / 2;
    pl_prev = 1'b0;
    pr_prev = 1'b0;
    n = 0;
    lfsr = 1;
  endtask

  // One clock cycle: drive inputs, let the edge happen, then compare at negedge.
  task automatic cyc(input logic kl, input logic kr, input logic h);
    bit pl, pr;
    key_l = kl;
    key_r = kr;
    halt  = h;
    @(posedge clk);
    @(negedge clk);
    n++;
    hl.push_front(kl);
    void'(hl.pop_back());
    pl = hl[2] && !hl[3];
`ifdef TUG_CPU_PLAYER_EN
    pr = 1'b0;
    if (n % (1 << DIV) == 0) begin
      pr = ((lfsr >> 7) & 7) < int'(cpu_level);
      lfsr = ((lfsr << 1) & 10'h3ff) | (((lfsr >> 9) ^ (lfsr >> 6)) & 1);
    end
`else
    hr.push_front(kr);
    void'(hr.pop_back());
    pr = hr[2] && !hr[3];
`endif
    if (!h && (pl_prev != pr_prev)) begin
      if (pl_prev) pos = (pos < N - 1) ? pos + 1 : pos;
      else         pos = (pos > 0) ? pos - 1 : pos;
    end
    pl_prev = pl;
    pr_prev = pr;
    if (l_press) lp_cnt++;
    if (r_press) rp_cnt++;
    check_eq("leds",    32'(leds),    32'(1 << pos));
    check_eq("l_on",    32'(l_on),    32'(pos == N - 1));
    check_eq("r_on",    32'(r_on),    32'(pos == 0));
    check_eq("l_press", 32'(l_press), 32'(pl));
    check_eq("r_press", 32'(r_press), 32'(pr));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_leds",    32'(leds),    32'(9'b000010000));
    check_eq("rst_l_on",    32'(l_on),    32'd0);
    check_eq("rst_r_on",    32'(r_on),    32'd0);
    check_eq("rst_l_press", 32'(l_press), 32'd0);
    check_eq("rst_r_press", 32'(r_press), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic press(input logic kl, input logic kr, input logic h);
    repeat (2) cyc(kl, kr, h);
    repeat (3) cyc(1'b0, 1'b0, h);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lp0, rp0;
    logic kl, kr, h;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // Reset behaviour and stability after release
    do_reset();
    repeat (4) cyc(1'b0, 1'b0, 1'b0);

`ifndef TUG_CPU_PLAYER_EN
    // Held key gives one pulse and one step left
    lp0 = lp_cnt;
    repeat (10) cyc(1'b1, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    check_eq("held_one_pulse", 32'(lp_cnt - lp0), 32'd1);
    check_eq("held_step_left", 32'(leds), 32'(9'b000100000));

    // Right saturation
    do_reset();
    repeat (6) press(1'b0, 1'b1, 1'b0);
    check_eq("sat_leds", 32'(leds), 32'(9'b000000001));
    check_eq("sat_r_on", 32'(r_on), 32'd1);

    // Simultaneous presses cancel
    do_reset();
    lp0 = lp_cnt;
    rp0 = rp_cnt;
    press(1'b1, 1'b1, 1'b0);
    check_eq("simul_l", 32'(lp_cnt - lp0), 32'd1);
    check_eq("simul_r", 32'(rp_cnt - rp0), 32'd1);
    check_eq("simul_leds", 32'(leds), 32'(9'b000010000));

    // Halt freezes position but pulses continue
    lp0 = lp_cnt;
    repeat (3) press(1'b1, 1'b0, 1'b1);
    check_eq("halt_pulses", 32'(lp_cnt - lp0), 32'd3);
    check_eq("halt_leds", 32'(leds), 32'(9'b000010000));
    press(1'b1, 1'b0, 1'b0);
    check_eq("unhalt_leds", 32'(leds), 32'(9'b000100000));
`else
    // CPU never presses at level 0
    cpu_level = 3'd0;
    rp0 = rp_cnt;
    repeat (200) cyc(1'b0, 1'b1, 1'b0);
    check_eq("cpu_lvl0", 32'(rp_cnt - rp0), 32'd0);
    // Max aggressiveness against the model LFSR
    do_reset();
    cpu_level = 3'd7;
    repeat (200) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
`endif

    // Randomized traffic with occasional halt and a mid-game reset
    kl = 1'b0;
    kr = 1'b0;
    h  = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) kl = ~kl;
      if ($urandom_range(0, 2) == 0) kr = ~kr;
      if ($urandom_range(0, 19) == 0) h = ~h;
`ifdef TUG_CPU_PLAYER_EN
      if ($urandom_range(0, 49) == 0) cpu_level = 3'($urandom_range(0, 7));
`endif
      if (i == 750) do_reset();
      cyc(kl, kr, h);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
